// File: rtl/instruction_fetch_unit.sv
// Fetch sequencer: reads the low then high instruction byte from byte-wide memory
// into the 16-bit IR through its half-select load port, advancing PC by two.
module instruction_fetch_unit #(
    parameter int ADDR_W      = 16,
    parameter int MEM_LATENCY = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Flush,
    input  logic              PCLoad,
    input  logic [ADDR_W-1:0] PCIn,
    input  logic [7:0]        MemData,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemRead,
    output logic              IR_Write,
    output logic              IR_LH,
    output logic [7:0]        IR_I,
    output logic [ADDR_W-1:0] PCOut,
    output logic              Busy,
    output logic              Done
);

    typedef enum logic [2:0] {
        IDLE, REQ_LO, WAIT_LO, WR_LO, REQ_HI, WAIT_HI, WR_HI, DONE
    } state_t;

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [ADDR_W-1:0] base, base_nxt;   // fetch start address, restored on Flush
    logic [CW-1:0]     cnt, cnt_nxt;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            pc    <= '0;
            base  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            base  <= base_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        base_nxt  = base;
        cnt_nxt   = cnt;
        MemAddr   = '0;
        MemRead   = 1'b0;
        IR_Write  = 1'b0;
        IR_LH     = 1'b0;
        IR_I      = 8'h00;
        Done      = 1'b0;
        Busy      = (state != IDLE);

        case (state)
            IDLE: begin
                if (PCLoad) pc_nxt = PCIn;
                if (Start) begin
                    base_nxt  = PCLoad ? PCIn : pc;
                    state_nxt = REQ_LO;
                end
            end
            REQ_LO, REQ_HI: begin
                MemRead = 1'b1;
                MemAddr = pc;
                if (MEM_LATENCY == 1) begin
                    state_nxt = (state == REQ_LO) ? WR_LO : WR_HI;
                end else begin
                    state_nxt = (state == REQ_LO) ? WAIT_LO : WAIT_HI;
                    cnt_nxt   = CNT_INIT;
                end
            end
            WAIT_LO, WAIT_HI: begin
                MemAddr = pc;
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) state_nxt = (state == WAIT_LO) ? WR_LO : WR_HI;
            end
            WR_LO, WR_HI: begin
                MemAddr   = pc;
                IR_Write  = 1'b1;
                IR_LH     = (state == WR_HI);
                IR_I      = MemData;
                pc_nxt    = pc + ADDR_W'(1);
                state_nxt = (state == WR_LO) ? REQ_HI : DONE;
            end
            DONE: begin
                Done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Abort overrides any progress made this cycle, including a PC increment
        if (Flush && state != IDLE) begin
            state_nxt = IDLE;
            pc_nxt    = base;
        end
    end

    assign PCOut = pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench: one fetch unit at memory latency 1, a second at latency 3,
// each with its own delayed-read memory model and IR register model.
module tb_instruction_fetch_unit;

    logic        Clock;
    logic        Reset;
    logic        start1, flush1, pcload1;
    logic [15:0] pcin1;
    logic [7:0]  memdata1;
    logic [15:0] memaddr1, pcout1;
    logic        memread1, irwrite1, irlh1, busy1, done1;
    logic [7:0]  iri1;

    logic        start3, flush3, pcload3;
    logic [15:0] pcin3;
    logic [7:0]  memdata3;
    logic [15:0] memaddr3, pcout3;
    logic        memread3, irwrite3, irlh3, busy3, done3;
    logic [7:0]  iri3;

    logic [7:0]  mem [0:65535];
    logic [7:0]  rd1;
    logic [7:0]  rd3 [0:2];
    logic [15:0] ir1, ir3;
    int          wr1, dn1, wr3, dn3;
    int          total, bad;

    instruction_fetch_unit #(.ADDR_W(16), .MEM_LATENCY(1)) u_dut1 (
        .Clock(Clock), .Reset(Reset), .Start(start1), .Flush(flush1),
        .PCLoad(pcload1), .PCIn(pcin1), .MemData(memdata1), .MemAddr(memaddr1),
        .MemRead(memread1), .IR_Write(irwrite1), .IR_LH(irlh1), .IR_I(iri1),
        .PCOut(pcout1), .Busy(busy1), .Done(done1)
    );

    instruction_fetch_unit #(.ADDR_W(16), .MEM_LATENCY(3)) u_dut3 (
        .Clock(Clock), .Reset(Reset), .Start(start3), .Flush(flush3),
        .PCLoad(pcload3), .PCIn(pcin3), .MemData(memdata3), .MemAddr(memaddr3),
        .MemRead(memread3), .IR_Write(irwrite3), .IR_LH(irlh3), .IR_I(iri3),
        .PCOut(pcout3), .Busy(busy3), .Done(done3)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Memory: data valid exactly MEM_LATENCY cycles after the read strobe, zero otherwise
    always @(posedge Clock) begin
        rd1    <= memread1 ? mem[memaddr1] : 8'h00;
        rd3[0] <= memread3 ? mem[memaddr3] : 8'h00;
        rd3[1] <= rd3[0];
        rd3[2] <= rd3[1];
    end
    assign memdata1 = rd1;
    assign memdata3 = rd3[2];

    // Instruction register models and event counters
    always @(posedge Clock) begin
        if (irwrite1) begin
            wr1 <= wr1 + 1;
            if (irlh1) ir1[15:8] <= iri1; else ir1[7:0] <= iri1;
        end
        if (done1) dn1 <= dn1 + 1;
        if (irwrite3) begin
            wr3 <= wr3 + 1;
            if (irlh3) ir3[15:8] <= iri3; else ir3[7:0] <= iri3;
        end
        if (done3) dn3 <= dn3 + 1;
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int w0, d0;

    initial begin
        total = 0; bad = 0;
        wr1 = 0; dn1 = 0; wr3 = 0; dn3 = 0;
        ir1 = 16'h0; ir3 = 16'h0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[16'h0000] = 8'h34; mem[16'h0001] = 8'h12;
        mem[16'hFFFF] = 8'hCD; mem[16'h0040] = 8'h5A; mem[16'h0041] = 8'hA5;
        for (int a = 0; a < 6; a++) mem[16'h0100 + a] = 8'(8'h11 * (a + 1));

        Reset = 1'b1;
        start1 = 0; flush1 = 0; pcload1 = 0; pcin1 = 16'h0;
        start3 = 0; flush3 = 0; pcload3 = 0; pcin3 = 16'h0;
        tick(); tick();
        Reset = 1'b0;

        // Reset state
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_memread", memread1, 0);
        chk("rst_irwrite", irwrite1, 0);
        chk("rst_memaddr", memaddr1, 16'h0);
        chk("rst_iri", iri1, 8'h0);
        chk("rst_pc", pcout1, 16'h0);

        // 1: basic fetch from 0
        start1 = 1; tick(); start1 = 0;
        chk("t1_req_lo_rd", memread1, 1);
        chk("t1_req_lo_addr", memaddr1, 16'h0000);
        tick();
        chk("t1_wr_lo", {irwrite1, irlh1, iri1}, {1'b1, 1'b0, 8'h34});
        tick();
        chk("t1_req_hi_addr", memaddr1, 16'h0001);
        tick();
        chk("t1_wr_hi", {irwrite1, irlh1, iri1}, {1'b1, 1'b1, 8'h12});
        tick();
        chk("t1_done", {done1, busy1}, 2'b11);
        chk("t1_pc", pcout1, 16'h0002);
        chk("t1_ir", ir1, 16'h1234);
        tick();
        chk("t1_idle", {done1, busy1}, 2'b00);

        // 2: PCLoad+Start, wrap from 0xFFFF
        pcload1 = 1; pcin1 = 16'hFFFF; start1 = 1; tick();
        pcload1 = 0; start1 = 0;
        chk("t2_addr_lo", {memread1, memaddr1}, {1'b1, 16'hFFFF});
        tick(); tick();
        chk("t2_addr_hi", {memread1, memaddr1}, {1'b1, 16'h0000});
        tick(); tick();
        chk("t2_done", done1, 1);
        chk("t2_pc", pcout1, 16'h0001);
        chk("t2_ir", ir1, 16'h34CD);
        tick();

        // 3: latency 3 on the second unit
        start3 = 1; tick(); start3 = 0;
        chk("t3_rd0", {memread3, memaddr3}, {1'b1, 16'h0000});
        tick();
        chk("t3_wait", {memread3, busy3, irwrite3}, 3'b010);
        tick(); tick();
        chk("t3_wr_lo", {irwrite3, irlh3, iri3}, {1'b1, 1'b0, 8'h34});
        tick();
        chk("t3_rd1", {memread3, memaddr3}, {1'b1, 16'h0001});
        tick(); tick(); tick();
        chk("t3_wr_hi", {irwrite3, irlh3, iri3}, {1'b1, 1'b1, 8'h12});
        tick();
        chk("t3_done", done3, 1);
        chk("t3_pc", pcout3, 16'h0002);
        tick();

        // 4: flush in WAIT_HI from base 0x40
        w0 = wr3; d0 = dn3;
        pcload3 = 1; pcin3 = 16'h0040; start3 = 1; tick();
        pcload3 = 0; start3 = 0;
        tick(); tick(); tick(); tick(); tick();
        chk("t4_in_wait_hi", {busy3, memread3, memaddr3}, {1'b1, 1'b0, 16'h0041});
        flush3 = 1; tick(); flush3 = 0;
        chk("t4_busy", busy3, 0);
        chk("t4_irwrite", irwrite3, 0);
        chk("t4_pc", pcout3, 16'h0040);
        chk("t4_writes", 32'(wr3 - w0), 1);
        chk("t4_dones", 32'(dn3 - d0), 0);
        chk("t4_ir_lo", ir3[7:0], 8'h5A);

        // 5: Start held for three back-to-back fetches from 0x100
        w0 = wr1; d0 = dn1;
        pcload1 = 1; pcin1 = 16'h0100; start1 = 1; tick();
        pcload1 = 0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 5 || c == 11) chk("t5_idle_gap", busy1, 0);
            if (c == 16) begin
                chk("t5_last_done", done1, 1);
                start1 = 0;
            end
        end
        tick();
        chk("t5_writes", 32'(wr1 - w0), 6);
        chk("t5_dones", 32'(dn1 - d0), 3);
        chk("t5_pc", pcout1, 16'h0106);
        chk("t5_ir", ir1, 16'h6655);
        chk("t5_stop", busy1, 0);

        // 6: reset in WR_LO
        w0 = wr1;
        start1 = 1; tick(); start1 = 0;
        tick();
        chk("t6_in_wr_lo", irwrite1, 1);
        Reset = 1; tick(); Reset = 0;
        chk("t6_outs", {busy1, done1, irwrite1, memread1, irlh1}, 5'b0);
        chk("t6_addr_pc_iri", {memaddr1, pcout1, iri1}, 40'h0);
        tick();
        chk("t6_single_write", 32'(wr1 - w0), 1);
        start1 = 1; tick(); start1 = 0;
        chk("t6_refetch_addr", {memread1, memaddr1}, {1'b1, 16'h0000});
        tick(); tick(); tick(); tick();
        chk("t6_done", done1, 1);
        chk("t6_pc", pcout1, 16'h0002);
        chk("t6_ir", ir1, 16'h1234);

        // Flush together with Start in IDLE: Start wins
        tick();
        flush1 = 1; start1 = 1; tick(); flush1 = 0; start1 = 0;
        chk("t7_flush_start", {busy1, memread1, memaddr1}, {1'b1, 1'b1, 16'h0002});
        tick(); tick(); tick(); tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
